// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
package regfile_arb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 16;

    // Register file select encoding: read is the safe idle level.
    localparam logic SELECT_READ  = 1'b1;
    localparam logic SELECT_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: one-hot grant plus the pointer to use after this access.
module rr_arbiter2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       next_ptr_o
);

    logic winner;

    // Pointer breaks ties; a lone requester wins outright.
    always_comb begin
        winner     = (req0_i && req1_i) ? ptr_i : req1_i;
        gnt_o      = 2'b00;
        if (req0_i || req1_i) begin
            gnt_o = winner ? 2'b10 : 2'b01;
        end
        next_ptr_o = ~winner;
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares a single-select register file between the core datapath (0) and the
// load/debug port (1). Every access runs IDLE -> SETUP -> EXEC -> FINISH so the
// level-sensitive write strobe never overlaps an address or data change.
//
// state  | meaning
// IDLE   | select high, register file pins hold; grant on any request
// SETUP  | latched address/data on the pins, select still high
// EXEC   | write: select low for this cycle; read: capture read data
// FINISH | select high, pins held, done pulse, pointer advances
module regfile_access_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] rAddr1_0,
    input  logic [AW-1:0] rAddr2_0,
    input  logic [AW-1:0] wAddr0,
    input  logic [DW-1:0] wData0,
    output logic          gnt0,
    output logic          done0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] rAddr1_1,
    input  logic [AW-1:0] rAddr2_1,
    input  logic [AW-1:0] wAddr1,
    input  logic [DW-1:0] wData1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rData1,
    output logic [DW-1:0] rData2,
    output logic          select,
    output logic [AW-1:0] readAddress1,
    output logic [AW-1:0] readAddress2,
    output logic [AW-1:0] writeAddress,
    output logic [DW-1:0] writeData,
    input  logic [DW-1:0] readData1,
    input  logic [DW-1:0] readData2
);

    state_t        state_q;
    logic          ptr_q, nxt_ptr_q;
    logic          we_q;
    logic          gnt0_q, gnt1_q, done0_q, done1_q;
    logic          select_q;
    logic [AW-1:0] raddr1_q, raddr2_q, waddr_q;
    logic [DW-1:0] wdata_q, rdata1_q, rdata2_q;

    logic [1:0]    arb_gnt;
    logic          arb_next_ptr;
    logic          we_d;
    logic [AW-1:0] raddr1_d, raddr2_d, waddr_d;
    logic [DW-1:0] wdata_d;

    rr_arbiter2 u_rr (
        .req0_i     (req0),
        .req1_i     (req1),
        .ptr_i      (ptr_q),
        .gnt_o      (arb_gnt),
        .next_ptr_o (arb_next_ptr)
    );

    // Request fields of whichever requester the arbiter picked.
    always_comb begin
        we_d     = arb_gnt[1] ? we1      : we0;
        raddr1_d = arb_gnt[1] ? rAddr1_1 : rAddr1_0;
        raddr2_d = arb_gnt[1] ? rAddr2_1 : rAddr2_0;
        waddr_d  = arb_gnt[1] ? wAddr1   : wAddr0;
        wdata_d  = arb_gnt[1] ? wData1   : wData0;
    end

    // Access sequencer; all register file pins and handshakes are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            nxt_ptr_q <= 1'b0;
            we_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            select_q  <= SELECT_READ;
            raddr1_q  <= '0;
            raddr2_q  <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    select_q <= SELECT_READ;
                    done0_q  <= 1'b0;
                    done1_q  <= 1'b0;
                    if (arb_gnt != 2'b00) begin
                        gnt0_q    <= arb_gnt[0];
                        gnt1_q    <= arb_gnt[1];
                        nxt_ptr_q <= arb_next_ptr;
                        we_q      <= we_d;
                        raddr1_q  <= raddr1_d;
                        raddr2_q  <= raddr2_d;
                        waddr_q   <= waddr_d;
                        wdata_q   <= wdata_d;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    select_q <= we_q ? SELECT_WRITE : SELECT_READ;
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    select_q <= SELECT_READ;
                    if (!we_q) begin
                        rdata1_q <= readData1;
                        rdata2_q <= readData2;
                    end
                    done0_q <= gnt0_q;
                    done1_q <= gnt1_q;
                    state_q <= ST_FINISH;
                end
                ST_FINISH: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    ptr_q   <= nxt_ptr_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    select_q <= SELECT_READ;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign select       = select_q;
    assign readAddress1 = raddr1_q;
    assign readAddress2 = raddr2_q;
    assign writeAddress = waddr_q;
    assign writeData    = wdata_q;
    assign rData1       = rdata1_q;
    assign rData2       = rdata2_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: a behavioural register file plus a
// reference model of register contents, pointer and last-latched pins.
module tb_regfile_access_arbiter;

    localparam int AW = 5;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] rAddr1_0 = '0, rAddr2_0 = '0, wAddr0 = '0;
    logic [AW-1:0] rAddr1_1 = '0, rAddr2_1 = '0, wAddr1 = '0;
    logic [DW-1:0] wData0 = '0, wData1 = '0;
    logic          gnt0, done0, gnt1, done1, select;
    logic [DW-1:0] rData1, rData2, writeData, readData1, readData2;
    logic [AW-1:0] readAddress1, readAddress2, writeAddress;

    always #5 clk = ~clk;

    regfile_access_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .rAddr1_0(rAddr1_0), .rAddr2_0(rAddr2_0),
        .wAddr0(wAddr0), .wData0(wData0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .we1(we1), .rAddr1_1(rAddr1_1), .rAddr2_1(rAddr2_1),
        .wAddr1(wAddr1), .wData1(wData1), .gnt1(gnt1), .done1(done1),
        .rData1(rData1), .rData2(rData2), .select(select),
        .readAddress1(readAddress1), .readAddress2(readAddress2),
        .writeAddress(writeAddress), .writeData(writeData),
        .readData1(readData1), .readData2(readData2)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'((i * 32'h1357) ^ 32'hA5A5);
    endfunction

    // Register file: combinational reads, write lands while select is low.
    logic [DW-1:0] rf [32];
    logic          rf_ready = 1'b0;
    always @(posedge clk) begin
        if (!rf_ready) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
            rf_ready <= 1'b1;
        end else if (select === 1'b0) begin
            rf[writeAddress] <= writeData;
        end
    end
    assign readData1 = rf[readAddress1];
    assign readData2 = rf[readAddress2];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] exp_rd1 = '0, exp_rd2 = '0, exp_wd = '0;
    logic [AW-1:0] exp_a1 = '0, exp_a2 = '0, exp_wa = '0;
    logic          exp_ptr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic gnt_of(input int r);
        return (r == 0) ? gnt0 : gnt1;
    endfunction

    function automatic logic done_of(input int r);
        return (r == 0) ? done0 : done1;
    endfunction

    task automatic drive(input int r, input logic rq, input logic we, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (r == 0) begin
            req0 = rq; we0 = we; rAddr1_0 = a1; rAddr2_0 = a2; wAddr0 = wa; wData0 = wd;
        end else begin
            req1 = rq; we1 = we; rAddr1_1 = a1; rAddr2_1 = a2; wAddr1 = wa; wData1 = wd;
        end
    endtask

    // One complete access by requester r; fields are scrambled after the grant.
    task automatic access(input int r, input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [DW-1:0] wd_late);
        int n = 0;
        logic g = 1'b0;
        drive(r, 1'b1, we, a1, a2, wa, wd);
        while (!g && n < 10) begin
            @(negedge clk);
            n++;
            g = gnt_of(r);
        end
        if (!g) begin
            check("gnt_timeout", 32'(0), 32'(1));
            drive(r, 1'b0, we, a1, a2, wa, wd);
            return;
        end
        check("grant_latency", 32'(n), 32'(1));
        check("setup_sel", 32'(select), 32'(1));
        check("setup_waddr", 32'(writeAddress), 32'(wa));
        check("setup_wdata", 32'(writeData), 32'(wd));
        check("setup_raddr1", 32'(readAddress1), 32'(a1));
        check("setup_raddr2", 32'(readAddress2), 32'(a2));
        check("setup_other_gnt", 32'(gnt_of(1 - r)), 32'(0));
        drive(r, 1'b1, ~we, a2, a1, ~wa, wd_late);
        @(negedge clk);
        check("exec_sel", 32'(select), 32'(we ? 1'b0 : 1'b1));
        check("exec_waddr", 32'(writeAddress), 32'(wa));
        check("exec_done", 32'(done_of(r)), 32'(0));
        @(negedge clk);
        drive(r, 1'b0, we, a1, a2, wa, wd);
        if (we) ref_mem[wa] = wd;
        else begin
            exp_rd1 = ref_mem[a1];
            exp_rd2 = ref_mem[a2];
        end
        exp_ptr = (r == 0);
        exp_a1 = a1; exp_a2 = a2; exp_wa = wa; exp_wd = wd;
        check("finish_done", 32'(done_of(r)), 32'(1));
        check("finish_gnt", 32'(gnt_of(r)), 32'(1));
        check("finish_other_done", 32'(done_of(1 - r)), 32'(0));
        check("finish_sel", 32'(select), 32'(1));
        check("finish_waddr", 32'(writeAddress), 32'(wa));
        check("finish_wdata", 32'(writeData), 32'(wd));
        check("rdata1", 32'(rData1), 32'(exp_rd1));
        check("rdata2", 32'(rData2), 32'(exp_rd2));
        @(negedge clk);
        check("idle_gnt", 32'(gnt_of(r)), 32'(0));
        check("idle_done", 32'(done_of(r)), 32'(0));
    endtask

    initial begin
        int owners[$];
        int last_done;
        int n;
        logic prev0, prev1;
        logic [DW-1:0] old9;

        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

        repeat (3) @(negedge clk);
        check("rst_sel", 32'(select), 32'(1));
        check("rst_gnt", 32'({gnt0, gnt1}), 32'(0));
        check("rst_done", 32'({done0, done1}), 32'(0));
        check("rst_addr", 32'({readAddress1, readAddress2, writeAddress}), 32'(0));
        check("rst_wdata", 32'(writeData), 32'(0));
        check("rst_rdata", 32'({rData1, rData2}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single write then read back; the late field change must be ignored.
        access(0, 1'b1, 5'd0, 5'd0, 5'd1, 16'd15, 16'd99);
        access(0, 1'b0, 5'd1, 5'd0, 5'd0, 16'd0, 16'd0);
        check("readback_reg1", 32'(rData1), 32'(15));
        access(1, 1'b1, 5'd0, 5'd0, 5'd3, 16'd10, 16'd77);
        access(1, 1'b0, 5'd1, 5'd3, 5'd0, 16'd0, 16'd0);
        check("dual_read_r1", 32'(rData1), 32'(15));
        check("dual_read_r2", 32'(rData2), 32'(10));
        access(0, 1'b1, 5'd0, 5'd0, 5'd5, 16'd15, 16'd99);
        access(1, 1'b0, 5'd5, 5'd5, 5'd0, 16'd0, 16'd0);
        check("field_change_reg5", 32'(rData1), 32'(15));

        // Randomised traffic against the reference model.
        for (int i = 0; i < 14; i++) begin
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   AW'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
        end

        // Contention: both requesters held high with identical read fields.
        drive(0, 1'b1, 1'b0, 5'd2, 5'd7, 5'd0, 16'd0);
        drive(1, 1'b1, 1'b0, 5'd2, 5'd7, 5'd0, 16'd0);
        prev0 = 1'b0; prev1 = 1'b0; last_done = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("never_both_gnt", 32'(gnt0 & gnt1), 32'(0));
            if (gnt0 && !prev0) owners.push_back(0);
            if (gnt1 && !prev1) owners.push_back(1);
            if (done0 || done1) begin
                if (last_done >= 0) check("done_period", 32'(c - last_done), 32'(4));
                last_done = c;
            end
            prev0 = gnt0; prev1 = gnt1;
        end
        drive(0, 1'b0, 1'b0, 5'd2, 5'd7, 5'd0, 16'd0);
        drive(1, 1'b0, 1'b0, 5'd2, 5'd7, 5'd0, 16'd0);
        n = 0;
        while ((gnt0 || gnt1) && n < 8) begin @(negedge clk); n++; end
        check("contention_drain", 32'(gnt0 | gnt1), 32'(0));
        check("contention_grants", 32'(owners.size()), 32'(5));
        foreach (owners[i]) check("rr_order", 32'(owners[i]), 32'(exp_ptr ^ 1'(i % 2)));
        if (owners.size() > 0) exp_ptr = (owners[owners.size() - 1] == 0);
        exp_rd1 = ref_mem[2]; exp_rd2 = ref_mem[7];
        exp_a1 = 5'd2; exp_a2 = 5'd7; exp_wa = 5'd0; exp_wd = 16'd0;
        check("contention_rdata1", 32'(rData1), 32'(exp_rd1));
        check("contention_rdata2", 32'(rData2), 32'(exp_rd2));

        // Requester 0 goes last so the pointer favours requester 1 before reset.
        access(0, 1'b0, 5'd4, 5'd6, 5'd0, 16'd0, 16'd0);
        old9 = ref_mem[9];
        drive(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 16'h1234);
        n = 0;
        while (!gnt0 && n < 10) begin @(negedge clk); n++; end
        check("rstw_gnt", 32'(gnt0), 32'(1));
        @(negedge clk);
        check("rstw_exec_sel", 32'(select), 32'(0));
        rst_n = 1'b0;
        #1;
        check("rstw_sel", 32'(select), 32'(1));
        check("rstw_gnt_clear", 32'({gnt0, gnt1}), 32'(0));
        check("rstw_done_clear", 32'({done0, done1}), 32'(0));
        check("rstw_addr_clear", 32'({readAddress1, readAddress2, writeAddress}), 32'(0));
        check("rstw_rdata_clear", 32'({rData1, rData2}), 32'(0));
        drive(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rstw_reg9_either", 32'((rf[9] === old9) || (rf[9] === 16'h1234)), 32'(1));
        ref_mem[9] = rf[9];
        exp_rd1 = '0; exp_rd2 = '0; exp_ptr = 1'b0;
        drive(0, 1'b1, 1'b0, 5'd8, 5'd10, 5'd0, 16'd0);
        drive(1, 1'b1, 1'b0, 5'd11, 5'd12, 5'd0, 16'd0);
        n = 0;
        while (!gnt0 && !gnt1 && n < 10) begin @(negedge clk); n++; end
        check("post_rst_gnt0", 32'(gnt0), 32'(1));
        check("post_rst_gnt1", 32'(gnt1), 32'(0));
        drive(0, 1'b0, 1'b0, 5'd8, 5'd10, 5'd0, 16'd0);
        drive(1, 1'b0, 1'b0, 5'd11, 5'd12, 5'd0, 16'd0);
        n = 0;
        while ((gnt0 || gnt1) && n < 8) begin @(negedge clk); n++; end
        check("post_rst_drain", 32'(gnt0 | gnt1), 32'(0));
        exp_rd1 = ref_mem[8]; exp_rd2 = ref_mem[10];
        exp_a1 = 5'd8; exp_a2 = 5'd10; exp_wa = 5'd0; exp_wd = 16'd0; exp_ptr = 1'b1;
        check("post_rst_rdata1", 32'(rData1), 32'(exp_rd1));
        check("post_rst_rdata2", 32'(rData2), 32'(exp_rd2));

        // Idle: pins must hold the last latched values with select high.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_sel", 32'(select), 32'(1));
            check("idle_pins", 32'({readAddress1, readAddress2, writeAddress}), 32'({exp_a1, exp_a2, exp_wa}));
            check("idle_wdata", 32'(writeData), 32'(exp_wd));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
